// File: rtl/spi_master_engine.sv
// spi_master_engine: SPI mode-0 burst master moving bytes between a data register file and the serial bus
module spi_master_engine #(
  parameter int N = 8,
  parameter int DIV = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         send,
  input  logic         all_1s,
  input  logic         all_0s,
  input  logic [N-1:0] n_tx_end,
  output logic [N-1:0] rd_addr,
  input  logic [31:0]  rd_data,
  output logic         wr_en,
  output logic [N-1:0] wr_addr,
  output logic [31:0]  wr_data,
  output logic         sclk,
  output logic         mosi,
  input  logic         miso,
  output logic         cs_n,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] n_rx_end
);
  typedef enum logic [2:0] {IDLE, LOAD, FETCH, SHIFT, STORE, DONE} state_t;
  state_t state;
  logic [N-1:0] idx, n_end;
  logic a1, a0;
  logic [7:0] tx, rx, cnt, fetched;
  logic [3:0] half;
  logic tick, unused_bits;
  assign rd_addr = idx;
  assign tick = cnt == 8'(DIV - 1);
  assign fetched = a1 ? 8'hFF : a0 ? 8'h00 : rd_data[7:0];
  assign unused_bits = ^rd_data[31:8];
  // burst sequencer: fetch a byte, shift it out while shifting one in, write it back
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      n_end <= '0;
      a1 <= 1'b0;
      a0 <= 1'b0;
      tx <= '0;
      rx <= '0;
      cnt <= '0;
      half <= '0;
      sclk <= 1'b0;
      mosi <= 1'b0;
      cs_n <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      n_rx_end <= '0;
    end else begin
      wr_en <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (send) begin
          state <= LOAD;
          idx <= '0;
          n_end <= n_tx_end;
          a1 <= all_1s;
          a0 <= all_0s;
          cs_n <= 1'b0;
          busy <= 1'b1;
        end
        LOAD: state <= FETCH;
        FETCH: begin
          tx <= fetched;
          mosi <= fetched[7];
          cnt <= '0;
          half <= '0;
          state <= SHIFT;
        end
        SHIFT: if (tick) begin
          cnt <= '0;
          sclk <= ~sclk;
          half <= half + 4'd1;
          if (!sclk) rx <= {rx[6:0], miso};
          else begin
            tx <= {tx[6:0], 1'b0};
            mosi <= tx[6];
          end
          if (half == 4'd15) begin
            state <= STORE;
            wr_en <= 1'b1;
            wr_addr <= idx;
            wr_data <= {24'b0, rx};
          end
        end else cnt <= cnt + 8'd1;
        STORE: if (idx == n_end) begin
          state <= DONE;
          done <= 1'b1;
          cs_n <= 1'b1;
          n_rx_end <= idx;
        end else begin
          idx <= idx + 1'b1;
          state <= LOAD;
        end
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_engine.sv
// tb_spi_master_engine: directed checks of the SPI burst master at DIV=2 and DIV=1
module tb_spi_master_engine;
  logic clk = 0, rst = 0, send = 0, send2 = 0, all_1s = 0, all_0s = 0;
  logic loop = 0, miso_fix = 0, miso;
  logic [7:0] n_tx_end = 0;
  logic [7:0] rd_addr, wr_addr, n_rx_end, rd_addr2, wr_addr2, n_rx_end2;
  logic [31:0] rd_data = 0, rd_data2 = 0, wr_data, wr_data2;
  logic wr_en, sclk, mosi, cs_n, busy, done;
  logic wr_en2, sclk2, mosi2, cs_n2, busy2, done2;
  logic [7:0] mem [256];
  int errors = 0, checks = 0;
  int wc = 0, dc = 0, rise = 0, cs_bad = 0, sc = 0, wc2 = 0, dc2 = 0, sc2 = 0;
  logic sd = 0, pb = 0, sd2 = 0, pb2 = 0;
  logic [7:0] wa [64];
  logic [31:0] wd [64];
  logic [31:0] wd2_last = 0;
  logic [7:0] mosi_bits = 0;

  assign miso = loop ? mosi : miso_fix;

  spi_master_engine #(.N(8), .DIV(2)) dut (
    .clk(clk), .rst(rst), .send(send), .all_1s(all_1s), .all_0s(all_0s),
    .n_tx_end(n_tx_end), .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .sclk(sclk), .mosi(mosi), .miso(miso),
    .cs_n(cs_n), .busy(busy), .done(done), .n_rx_end(n_rx_end));

  spi_master_engine #(.N(8), .DIV(1)) dut2 (
    .clk(clk), .rst(rst), .send(send2), .all_1s(1'b0), .all_0s(1'b0),
    .n_tx_end(8'd0), .rd_addr(rd_addr2), .rd_data(rd_data2), .wr_en(wr_en2),
    .wr_addr(wr_addr2), .wr_data(wr_data2), .sclk(sclk2), .mosi(mosi2), .miso(1'b0),
    .cs_n(cs_n2), .busy(busy2), .done(done2), .n_rx_end(n_rx_end2));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd_data <= {24'b0, mem[rd_addr]};
    rd_data2 <= {24'b0, mem[rd_addr2]};
  end

  always @(posedge sclk) begin
    rise++;
    mosi_bits = {mosi_bits[6:0], mosi};
  end

  always @(negedge clk) begin
    if (wr_en) begin
      wa[wc % 64] = wr_addr;
      wd[wc % 64] = wr_data;
      wc++;
    end
    if (done) dc++;
    if (busy && !done && cs_n) cs_bad++;
    if (busy && !pb) begin sc = 1; sd = 0; end
    else if (busy && !sd) sc++;
    if (wr_en && !sd) sd = 1;
    pb = busy;
    if (wr_en2) begin wd2_last = wr_data2; wc2++; end
    if (done2) dc2++;
    if (busy2 && !pb2) begin sc2 = 1; sd2 = 0; end
    else if (busy2 && !sd2) sc2++;
    if (wr_en2 && !sd2) sd2 = 1;
    pb2 = busy2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic burst(input logic [7:0] n, input logic a1, input logic a0, input bit resend);
    int b = dc;
    @(negedge clk);
    n_tx_end = n; all_1s = a1; all_0s = a0; send = 1;
    @(negedge clk);
    send = 0;
    for (int i = 0; i < 4000 && dc == b; i++) begin
      @(negedge clk);
      if (resend && i == 20) begin send = 1; all_1s = ~a1; n_tx_end = 8'd7; end
      else send = 0;
    end
    send = 0;
    check("burst_done", dc - b, 1);
    repeat (3) @(negedge clk);
    check("single_done", dc - b, 1);
  endtask

  initial begin
    int b, r;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    #12;
    check("rst_sclk", sclk, 0);
    check("rst_cs_n", cs_n, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_n_rx_end", n_rx_end, 0);
    @(negedge clk); rst = 1;
    repeat (2) @(negedge clk);

    mem[0] = 8'hA5; loop = 1; b = wc;
    burst(8'd0, 0, 0, 0);
    check("t1_mosi_bits", mosi_bits, 8'hA5);
    check("t1_writes", wc - b, 1);
    check("t1_addr", wa[b % 64], 0);
    check("t1_data", wd[b % 64], 32'h000000A5);
    check("t1_n_rx_end", n_rx_end, 0);
    check("t1_span", sc, 35);
    check("t1_idle_cs", cs_n, 1);
    check("t1_idle_busy", busy, 0);

    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; loop = 0; miso_fix = 1; b = wc; cs_bad = 0;
    burst(8'd2, 0, 0, 0);
    check("t2_writes", wc - b, 3);
    for (int k = 0; k < 3; k++) begin
      check("t2_addr", wa[(b + k) % 64], k);
      check("t2_data", wd[(b + k) % 64], 32'h000000FF);
    end
    check("t2_cs_low", cs_bad, 0);
    check("t2_n_rx_end", n_rx_end, 2);

    miso_fix = 0; b = wc;
    burst(8'd0, 1, 1, 0);
    check("t3_mosi_bits", mosi_bits, 8'hFF);
    check("t3_data", wd[b % 64], 0);

    mem[0] = 8'h5A; mem[1] = 8'h6B; loop = 1; b = wc;
    burst(8'd1, 0, 0, 1);
    all_1s = 0; n_tx_end = 0;
    check("t4_writes", wc - b, 2);
    check("t4_data0", wd[b % 64], 32'h5A);
    check("t4_data1", wd[(b + 1) % 64], 32'h6B);
    check("t4_n_rx_end", n_rx_end, 1);

    mem[0] = 8'hC3; b = wc; r = rise;
    @(negedge clk); send = 1;
    @(negedge clk); send = 0;
    for (int i = 0; i < 500 && rise - r < 4; i++) begin @(posedge clk); #1; end
    check("t5_sclk_high", sclk, 1);
    rst = 0; #1;
    check("t5_sclk_rst", sclk, 0);
    check("t5_cs_rst", cs_n, 1);
    check("t5_busy_rst", busy, 0);
    repeat (4) @(negedge clk);
    rst = 1;
    repeat (30) @(negedge clk);
    check("t5_no_write", wc - b, 0);
    mem[0] = 8'h3C;
    burst(8'd0, 0, 0, 0);
    check("t5_writes", wc - b, 1);
    check("t5_addr", wa[b % 64], 0);
    check("t5_data", wd[b % 64], 32'h3C);

    b = wc2;
    @(negedge clk); send2 = 1;
    @(negedge clk); send2 = 0;
    for (int i = 0; i < 200 && dc2 == 0; i++) @(negedge clk);
    check("t6_done", dc2, 1);
    check("t6_writes", wc2 - b, 1);
    check("t6_span", sc2, 19);
    check("t6_data", wd2_last, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_master_engine.md
SPI_MASTER_ENGINE -- requirements
Module: spi_master_engine

Interface
REQ-001 Parameter N, default 8, data-register address width; transaction count field width.
REQ-002 Parameter DIV, default 2, system-clock cycles per SCLK half-period; legal range 1..255.
REQ-003 clk  in  1  system clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 send  in  1  start request, sampled only in IDLE.
REQ-006 all_1s  in  1  transmit 0xFF for every byte, ignoring data register contents.
REQ-007 all_0s  in  1  transmit 0x00 for every byte; all_1s has priority when both are set.
REQ-008 n_tx_end  in  N  number of byte transactions minus one.
REQ-009 rd_addr  out  N  data-register read address.
REQ-010 rd_data  in  32  data-register read data, valid one clk after rd_addr is driven; byte in [7:0].
REQ-011 wr_en  out  1  one-cycle write strobe to data register.
REQ-012 wr_addr  out  N  data-register write address.
REQ-013 wr_data  out  32  {24'b0, received byte}.
REQ-014 sclk  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-015 mosi  out  1  serial data out, MSB first.
REQ-016 miso  in  1  serial data in, MSB first.
REQ-017 cs_n  out  1  chip select, active low.
REQ-018 busy  out  1  high from the cycle after send is accepted until the DONE cycle inclusive.
REQ-019 done  out  1  one-cycle pulse at end of a burst.
REQ-020 n_rx_end  out  N  index of last byte received, held until the next burst completes.

Function
REQ-021 FSM states SHALL be IDLE, LOAD, FETCH, SHIFT, STORE, DONE.
REQ-022 IDLE: send=1 -> LOAD; idx cleared to 0; cs_n driven low at entry to LOAD.
REQ-023 LOAD: rd_addr=idx for one cycle -> FETCH.
REQ-024 FETCH: tx shift register loaded from rd_data[7:0], or 0xFF/0x00 per REQ-006/007 -> SHIFT.
REQ-025 SHIFT: mosi presents tx bit 7 from the first SHIFT cycle; sclk toggles every DIV cycles starting low.
REQ-026 miso SHALL be sampled on each sclk rising edge; mosi advances on each sclk falling edge.
REQ-027 SHIFT ends after 16 half-periods (8 full SCLK cycles, sclk low) -> STORE; SHIFT lasts exactly 16*DIV cycles.
REQ-028 STORE: wr_en=1, wr_addr=idx, wr_data={24'b0, rx byte} for exactly one cycle.
REQ-029 STORE: idx==n_tx_end -> DONE; otherwise idx+1 -> LOAD; cs_n stays low between bytes.
REQ-030 DONE: cs_n high, done=1, n_rx_end=idx, one cycle -> IDLE.
REQ-031 Per-byte latency LOAD->STORE inclusive SHALL be 16*DIV+3 cycles.
REQ-032 n_tx_end=2^N-1 SHALL perform 2^N transactions; idx SHALL NOT wrap before DONE.
REQ-033 send asserted while busy SHALL be ignored; all_1s, all_0s, n_tx_end are sampled only on send acceptance.
REQ-034 wr_en SHALL never assert outside STORE; rd_addr holds idx in all states.

Reset
REQ-035 On rst low, asynchronously: state IDLE, sclk=0, mosi=0, cs_n=1, busy=0, done=0, wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, n_rx_end=0, idx=0.
REQ-036 Reset during SHIFT SHALL abort the burst with no further wr_en; first send after reset release starts a fresh burst at idx 0.

Verification
REQ-037 DIV=2, n_tx_end=0, rd_data[7:0]=0xA5, miso loopback from mosi -> mosi bits 1,0,1,0,0,1,0,1; wr_en once at addr 0 with wr_data=0x000000A5; done one pulse; n_rx_end=0.
REQ-038 n_tx_end=2, register bytes 0x11,0x22,0x33, miso tied 1 -> three STORE writes at addr 0,1,2 of 0xFF; cs_n low continuously from LOAD to DONE.
REQ-039 all_1s=1 and all_0s=1, miso tied 0 -> mosi constant 1; wr_data=0x00000000.
REQ-040 send pulsed again mid-burst -> ignored; exactly n_tx_end+1 writes; single done pulse.
REQ-041 rst low during 4th sclk rising edge -> sclk=0, cs_n=1 in same cycle; no wr_en; next send completes normally.
REQ-042 DIV=1, n_tx_end=0 -> SHIFT lasts 16 cycles, LOAD->STORE span 19 cycles.
